// File: rtl/user_bram_pkg.sv
// Shared constants and FSM state encoding for the user-project BRAM Wishbone slave.
package user_bram_pkg;

    localparam logic [7:0] BASE_HI    = 8'h38;
    localparam int         DELAYS_MAX = 255;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_ACK    = 2'd3;

endpackage

// File: rtl/user_bram_wb_ctrl_if.sv
// Caravel Wishbone slave-side signal bundle (names kept as seen from the slave).
interface user_bram_wb_ctrl_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/user_bram_1rw.sv
// Single-port 32-bit BRAM with per-byte write enables and a registered, read-first output.
module user_bram_1rw #(
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= r_mem[addr];
        end
    end

endmodule

// File: rtl/user_bram_wb_ctrl.sv
// Wishbone slave for the mprjram window with a programmable wait-state delay before each BRAM access.
// Optional traffic counters on la_data_out when USER_BRAM_PERF_EN is defined.
module user_bram_wb_ctrl
    import user_bram_pkg::*;
#(
    parameter int         DELAYS    = 10,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] BASE_HI   = user_bram_pkg::BASE_HI,
    parameter string      INIT_FILE = ""
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_bram_wb_ctrl_if.slave   wbs,
    output logic [63:0]          la_data_out
);

    generate
        if (DELAYS < 1 || DELAYS > DELAYS_MAX) begin : g_bad_delays
            $error("user_bram_wb_ctrl: DELAYS must be in 1..255");
        end
    endgenerate

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdata;

    logic              w_req;
    logic              w_hit;
    logic              w_en;
    logic [3:0]        w_bram_we;
    logic [31:0]       w_rdata;
    logic              w_ack;
    logic              w_unused;

    assign w_req = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_hit = w_req & (wbs.wbs_adr_i[31:24] == BASE_HI);

    // Upper window bits alias modulo the depth; byte offset is irrelevant for word access.
    assign w_unused = ^{wbs.wbs_adr_i[23:ADDR_W+2], wbs.wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 8'(DELAYS - 1);
                    end
                end
                ST_WAIT: begin
                    // Master gave up during the wait: nothing has touched the BRAM yet.
                    if (!w_req)              r_state <= ST_IDLE;
                    else if (r_cnt == 8'd0)  r_state <= ST_ACCESS;
                    else                     r_cnt   <= r_cnt - 8'd1;
                end
                ST_ACCESS: r_state <= ST_ACK;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (r_state == ST_IDLE && w_hit) begin
            r_addr  <= wbs.wbs_adr_i[ADDR_W+1:2];
            r_we    <= wbs.wbs_we_i;
            r_sel   <= wbs.wbs_sel_i;
            r_wdata <= wbs.wbs_dat_i;
        end
    end

    assign w_en      = (r_state == ST_ACCESS);
    assign w_bram_we = (w_en && r_we) ? r_sel : 4'b0000;

    user_bram_1rw #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk   (wb_clk_i),
        .en    (w_en),
        .we    (w_bram_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign w_ack         = (r_state == ST_ACK);
    assign wbs.wbs_ack_o = w_ack;
    assign wbs.wbs_dat_o = (w_ack && !r_we) ? w_rdata : 32'h0;

`ifdef USER_BRAM_PERF_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (w_ack) begin
            if (r_we) r_wr_cnt <= r_wr_cnt + 32'd1;
            else      r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign la_data_out = {r_wr_cnt, r_rd_cnt};
`else
    assign la_data_out = 64'h0;
`endif

endmodule

// File: tb/tb_user_bram_wb_ctrl.sv
// Directed bench for user_bram_wb_ctrl: word-memory model with per-cycle compare plus literal spot checks.
module tb_user_bram_wb_ctrl;

    localparam int D     = 10;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] la;

    user_bram_wb_ctrl_if bus();

    user_bram_wb_ctrl #(.DELAYS(D)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (bus),
        .la_data_out (la)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Model: word store, the pending transfer, and traffic counters.
    logic [31:0] mdl_mem [int];
    int          exp_ack_cyc = -1;
    logic        e_we;
    int          e_idx;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic [31:0] m_rd = 0;
    logic [31:0] m_wr = 0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_rd = 0;
            m_wr = 0;
        end
    end

    always @(negedge clk) begin
        logic        ea;
        logic [31:0] ed;
        logic [31:0] w;
        logic [63:0] el;
        if (mon_en) begin
            ea = (cyc_n == exp_ack_cyc);
            ed = 32'h0;
            if (ea && !e_we) ed = mdl_mem.exists(e_idx) ? mdl_mem[e_idx] : 32'h0;
`ifdef USER_BRAM_PERF_EN
            el = {m_wr, m_rd};
`else
            el = 64'h0;
`endif
            check("mon_ack", {63'h0, bus.wbs_ack_o}, {63'h0, ea});
            check("mon_dat", {32'h0, bus.wbs_dat_o}, {32'h0, ed});
            check("mon_la", la, el);
            if (ea) begin
                if (e_we) begin
                    w = mdl_mem.exists(e_idx) ? mdl_mem[e_idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (e_sel[b]) w[8*b +: 8] = e_dat[8*b +: 8];
                    mdl_mem[e_idx] = w;
                    m_wr = m_wr + 1;
                end else begin
                    m_rd = m_rd + 1;
                end
            end
        end
    end

    // mode: 0 normal, 1 miss, 2 drop stb 3 cycles after accept, 3 reset in WAIT
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode, output logic [31:0] rdat);
        int k;
        int bound;
        bit got;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        if (adr[31:24] == 8'h38) begin
            exp_ack_cyc = cyc_n + D + 2;
            e_we  = we;
            e_idx = int'((adr >> 2) % DEPTH);
            e_dat = dat;
            e_sel = sel;
        end
        if (mode == 2) begin
            repeat (3) @(negedge clk);
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            exp_ack_cyc = -1;
        end else if (mode == 3) begin
            repeat (4) @(negedge clk);
            rst = 1'b1;
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            exp_ack_cyc = -1;
            @(negedge clk);
            rst = 1'b0;
        end
        k     = 0;
        got   = 0;
        rdat  = 32'h0;
        bound = (mode == 1) ? 300 : (mode == 0 ? 40 : 30);
        while (k < bound) begin
            @(negedge clk);
            k++;
            if (bus.wbs_ack_o) begin
                got  = 1;
                rdat = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        if (mode == 0) begin
            check("ack_seen", {63'h0, got}, 64'd1);
            check("latency", 64'(k), 64'd12);
        end else begin
            check("no_ack", {63'h0, got}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] la_exp;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", {63'h0, bus.wbs_ack_o}, 64'd0);
        check("rst_dat", {32'h0, bus.wbs_dat_o}, 64'd0);
        check("rst_la", la, 64'd0);
        rst = 1'b0;
        mon_en = 1;

        xfer(1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF, 0, r);
        xfer(1'b1, 32'h3800_0008, 32'hCAFE_F00D, 4'hF, 0, r);
        xfer(1'b1, 32'h3800_0010, 32'hFFFF_FFFF, 4'hF, 3, r);

        // Counters restart from the reset above: 5 reads and 3 writes follow.
        xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, r);
        check("rst_word_kept", {32'h0, r}, {32'h0, 32'h1234_5678});
        xfer(1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 0, r);
        xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, 0, r);
        check("rd_deadbeef", {32'h0, r}, {32'h0, 32'hDEAD_BEEF});
        xfer(1'b1, 32'h3800_0004, 32'h0000_AB00, 4'b0010, 0, r);
        xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, 0, r);
        check("rd_bytelane", {32'h0, r}, {32'h0, 32'hDEAD_ABEF});
        xfer(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, 1, r);
        xfer(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, 1, r);
        xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, 0, r);
        check("miss_unchanged", {32'h0, r}, {32'h0, 32'hDEAD_ABEF});
        xfer(1'b1, 32'h3800_0008, 32'h0000_0001, 4'hF, 2, r);
        xfer(1'b0, 32'h3800_0008, 32'h0, 4'hF, 0, r);
        check("abort_unchanged", {32'h0, r}, {32'h0, 32'hCAFE_F00D});
        xfer(1'b1, 32'h3801_0007, 32'h0BAD_C0DE, 4'hF, 0, r);

        repeat (2) @(negedge clk);
`ifdef USER_BRAM_PERF_EN
        la_exp = {32'd3, 32'd5};
`else
        la_exp = 64'h0;
`endif
        check("la_counts", la, la_exp);

        xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, 0, r);
        check("alias_word", {32'h0, r}, {32'h0, 32'h0BAD_C0DE});

        repeat (3) @(negedge clk);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
